// File: rtl/rr_packet_allocator.sv
// Packet-locked round-robin allocator for one output port: grant registered one edge after request, held until tail transfer.
// Optional ALLOC_TIMEOUT_EN builds a stall counter that forces release after MAX_HOLD cycles without a transfer.
`ifndef NPORT
`define NPORT 5
`endif

module rr_packet_allocator #(
  parameter int size     = `NPORT,
  parameter int MAX_HOLD = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [size-1:0]          i_requests,
  input  logic [size-1:0]          i_tail,
  input  logic                     i_outReady,
  input  logic                     i_enable,
  output logic                     o_isOutputSelected,
  output logic [$clog2(size)-1:0]  o_selectedOutput,
  output logic [size-1:0]          o_grant,
  output logic                     o_timeout
);

  localparam int W = $clog2(size);
  localparam logic [size-1:0] ONE_HOT0 = {{(size-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LAST_IDX = W'(size - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   win_idx;
  logic           win_found;
  logic           xfer;
  logic           tail_xfer;
  logic           forced;
  logic [W-1:0]   next_ptr;

  // First requesting port at or after ptr, wrapping at size rather than 2^W.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < size; k++) begin
      idx = int'(ptr) + k;
      if (idx >= size) idx = idx - size;
      if (!win_found && i_requests[idx]) begin
        win_found = 1'b1;
        win_idx   = W'(idx);
      end
    end
  end

  assign xfer      = (state == LOCKED) && i_requests[o_selectedOutput] && i_outReady;
  assign tail_xfer = xfer && i_tail[o_selectedOutput];
  assign next_ptr  = (o_selectedOutput == LAST_IDX) ? '0 : o_selectedOutput + 1'b1;

`ifdef ALLOC_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);

  logic [15:0] hold_cnt;

  // A tail transfer on the limit cycle wins: normal release, no timeout pulse.
  assign forced = (state == LOCKED) && !tail_xfer && (hold_cnt == HOLD_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state != LOCKED || xfer || forced) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      ptr                <= '0;
      o_isOutputSelected <= 1'b0;
      o_selectedOutput   <= '0;
      o_grant            <= '0;
      o_timeout          <= 1'b0;
    end else begin
      o_timeout <= forced;
      case (state)
        IDLE: begin
          if (i_enable && win_found) begin
            state              <= LOCKED;
            o_isOutputSelected <= 1'b1;
            o_selectedOutput   <= win_idx;
            o_grant            <= ONE_HOT0 << win_idx;
          end
        end
        LOCKED: begin
          // Request drops while locked are bubbles inside the packet, not releases.
          if (tail_xfer || forced) begin
            state              <= IDLE;
            ptr                <= next_ptr;
            o_isOutputSelected <= 1'b0;
            o_selectedOutput   <= '0;
            o_grant            <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_allocator.sv
// Directed bench for rr_packet_allocator with size 5; timeout scenario follows ALLOC_TIMEOUT_EN.
module tb_rr_packet_allocator;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] i_requests;
  logic [4:0] i_tail;
  logic       i_outReady;
  logic       i_enable;
  logic       o_isOutputSelected;
  logic [2:0] o_selectedOutput;
  logic [4:0] o_grant;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;

  rr_packet_allocator #(.size(5), .MAX_HOLD(8)) dut (
    .clock              (clock),
    .reset              (reset),
    .i_requests         (i_requests),
    .i_tail             (i_tail),
    .i_outReady         (i_outReady),
    .i_enable           (i_enable),
    .o_isOutputSelected (o_isOutputSelected),
    .o_selectedOutput   (o_selectedOutput),
    .o_grant            (o_grant),
    .o_timeout          (o_timeout)
  );

  always #5 clock = ~clock;

  // {selected, index, one-hot grant, timeout}
  logic [9:0] obs;
  assign obs = {o_isOutputSelected, o_selectedOutput, o_grant, o_timeout};

  function automatic logic [9:0] ev(input bit locked, input int port, input bit to);
    logic [4:0] g;
    logic [2:0] s;
    g = locked ? (5'b00001 << port) : 5'b00000;
    s = locked ? 3'(port) : 3'd0;
    return {locked, s, g, to};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    i_requests = '0;
    i_tail     = '0;
    i_outReady = 1'b0;
    i_enable   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    reset      = 1'b1;
    i_requests = '0;
    i_tail     = '0;
    i_outReady = 1'b1;
    i_enable   = 1'b1;
    exp = ev(0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_held cyc %0d: got %b want %b", c, obs, exp);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_rotation();
    int exp_port[5] = '{0, 2, 4, 0, 2};
    logic [9:0] exp;
    apply_reset();
    i_requests = 5'b10101;
    i_tail     = 5'b11111;
    i_outReady = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      exp = ev(1, exp_port[g], 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rotation_grant %0d: got %b want %b", g, obs, exp);
      end
      tick();
      exp = ev(0, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rotation_bubble %0d: got %b want %b", g, obs, exp);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [9:0] exp;
    apply_reset();
    i_requests = 5'b01010;
    tick();
    exp = ev(1, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lock_first: got %b want %b", obs, exp);
    end
    // Ready toggles 1,0,1,0..: transfers on cycles 1,3,5,7; the 4th flit is the tail.
    for (int c = 1; c <= 7; c++) begin
      i_outReady = (c % 2) == 1;
      i_tail     = (c >= 6) ? 5'b00010 : 5'b00000;
      tick();
      exp = (c < 7) ? ev(1, 1, 0) : ev(0, 0, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL lock_hold cyc %0d: got %b want %b", c, obs, exp);
      end
    end
    i_tail = '0;
    tick();
    exp = ev(1, 3, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL lock_next_port3: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_disable();
    logic [9:0] exp;
    apply_reset();
    i_requests = 5'b00100;
    tick();
    exp = ev(1, 2, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL disable_lock: got %b want %b", obs, exp);
    end
    i_enable = 1'b0;
    tick();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL disable_midpacket: got %b want %b", obs, exp);
    end
    i_outReady = 1'b1;
    i_tail     = 5'b00100;
    tick();
    exp = ev(0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL disable_complete: got %b want %b", obs, exp);
    end
    i_tail = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL disable_idle cyc %0d: got %b want %b", c, obs, exp);
      end
    end
    i_enable = 1'b1;
    tick();
    exp = ev(1, 2, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL disable_reenable: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_reset_midpacket();
    logic [9:0] exp;
    apply_reset();
    i_requests = 5'b00100;
    tick();
    i_outReady = 1'b1;
    tick();
    tick();
    exp = ev(1, 2, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_locked: got %b want %b", obs, exp);
    end
    i_outReady = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp = ev(0, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_async_drop: got %b want %b", obs, exp);
    end
    tick();
    reset      = 1'b0;
    i_requests = 5'b00110;
    tick();
    exp = ev(1, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_after_reset: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] exp;
    apply_reset();
    i_requests = 5'b00001;
    tick();
    exp = ev(1, 0, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL timeout_lock: got %b want %b", obs, exp);
    end
    i_requests = 5'b00011;
`ifdef ALLOC_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = (k < 9) ? ev(1, 0, 0) : ev(0, 0, 1);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout_count edge %0d: got %b want %b", k, obs, exp);
      end
    end
    tick();
    exp = ev(1, 1, 0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL timeout_next_port1: got %b want %b", obs, exp);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout_held edge %0d: got %b want %b", k, obs, exp);
      end
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rotation();
    test_packet_lock();
    test_disable();
    test_reset_midpacket();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
